dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Arbitrates the single data-memory port between the pipeline MEM stage and the debug unit's memory-dump engine. The CPU has priority; debug reads use idle slots, with a bounded-wait guarantee that forces a debug slot and stalls the pipeline for one cycle. It sequences multi-word dumps (base address + count) and presents each word to the debug unit over a valid/ready handshake. It sits between the MEM stage, the debug/UART unit and the data memory.

Parameters:
ADDR_W, 5, word-address width; memory depth = 2^ADDR_W (default 32 words)
DATA_W, 32, data width
MAX_WAIT, 4, idle cycles debug may be denied before a slot is forced (>=1)

Ports:
clk  in  1  clock, posedge
rst  in  1  reset, asynchronous, active-high
cpu_rw  in  2  MEM stage request: 00 idle, 01 write, 10 read, 11 treated as idle
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data to CPU (= mem_rdata)
cpu_stall  out  1  CPU request not serviced this cycle; hold request
dbg_start  in  1  start-dump pulse
dbg_abort  in  1  cancel the dump in progress
dbg_base  in  ADDR_W  first dump address
dbg_count  in  ADDR_W+1  words to dump (0..2^ADDR_W)
dbg_data  out  DATA_W  dumped word
dbg_valid  out  1  dbg_data valid
dbg_ready  in  1  debug unit accepts dbg_data
dbg_busy  out  1  dump in progress (state != IDLE)
dbg_done  out  1  one-cycle pulse at the end of the dump
mem_rw  out  2  to memory: 00 idle, 01 write, 10 read
mem_addr  out  ADDR_W  to memory
mem_wdata  out  DATA_W  to memory
mem_rdata  in  DATA_W  from memory; valid one cycle after a read is issued

Behaviour:
- Reset (async): state IDLE; cur_addr, remaining, wait_cnt, dbg_data = 0; dbg_valid, dbg_done = 0. All combinational outputs resolve to the idle mux path.
- cpu_req = (cpu_rw == 01 || cpu_rw == 10).
- grant_dbg = (state == ISSUE) && (!cpu_req || wait_cnt == MAX_WAIT).
- Combinational mux:
  - grant_dbg: mem_rw = 10, mem_addr = cur_addr.
  - else cpu_req: pass the CPU request through (mem_rw = cpu_rw, mem_addr = cpu_addr, mem_wdata = cpu_wdata).
  - else: mem_rw = 00.
- cpu_stall = grant_dbg && cpu_req.
- FSM states: IDLE, ISSUE, WAIT_DATA, PRESENT, DONE.
  - IDLE:
    - dbg_start with dbg_count != 0: latch cur_addr = dbg_base, remaining = dbg_count, wait_cnt = 0; go to ISSUE.
    - dbg_start with dbg_count == 0: go to DONE.
  - ISSUE:
    - grant_dbg: go to WAIT_DATA, wait_cnt = 0.
    - Otherwise: wait_cnt++ and stay in ISSUE.
  - WAIT_DATA: dbg_data <= mem_rdata, dbg_valid <= 1; go to PRESENT. The CPU owns the port in this cycle.
  - PRESENT: hold dbg_data and dbg_valid until dbg_ready. On the handshake:
    - dbg_valid <= 0, remaining--, cur_addr++ (wraps mod 2^ADDR_W).
    - Go to DONE if remaining was 1, else go to ISSUE.
    - The CPU owns the port throughout PRESENT.
  - DONE: dbg_done = 1 for exactly one cycle; go to IDLE.
- dbg_start outside IDLE is ignored.
- dbg_abort in ISSUE, WAIT_DATA or PRESENT:
  - Next state is IDLE; dbg_valid cleared; no dbg_done pulse.
  - Takes precedence over a dbg_ready handshake in the same cycle.
  - A read already issued completes at the memory; its data is discarded.
- Latency:
  - With the CPU idle, dbg_valid rises 2 cycles after ISSUE is entered.
  - Worst case with the CPU busy: MAX_WAIT + 2 cycles.
- At most one forced stall per dumped word.
- A CPU write is never overridden except by a forced slot, in which case it is stalled (not dropped).
- Reset mid-dump: immediate return to IDLE with reset values; no dbg_done pulse.

Test Plan:
- CPU idle, start base=2 count=3, dbg_ready=1 -> mem reads at 2,3,4; three dbg_valid beats with preloaded data; dbg_done 1 cycle; cpu_stall never asserted.
- CPU issues reads every cycle, start count=1, MAX_WAIT=4 -> debug waits 4 cycles; 5th ISSUE cycle gives mem_rw=10 and cpu_stall=1 for exactly 1 cycle; CPU read then serviced the next cycle.
- base=30, count=4 -> addresses 30,31,0,1 (wrap); count=32 from base 0 -> all 32 words, done after the 32nd handshake.
- dbg_ready held low 5 cycles in PRESENT -> dbg_data stable, dbg_valid high, no further mem_rw=10, CPU writes pass unstalled.
- count=0 -> dbg_done 1 cycle after start, no memory access.
- Abort in PRESENT (also async rst in WAIT_DATA) -> IDLE next cycle, dbg_valid=0, no dbg_done; dbg_start while busy -> ignored, dump continues unchanged.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory port arbiter: CPU MEM stage has priority, debug dump engine reads in idle slots.
// Latency: comb mux to memory; a dump word reaches dbg_valid 2 cycles after ISSUE (MAX_WAIT+2 worst case).
// Backpressure: CPU held via cpu_stall on a forced debug slot; dump word held until dbg_ready.
// Ports: cpu_* = MEM stage request/response, dbg_* = dump control and valid/ready word stream,
//        mem_* = single-port data memory (read data returns one cycle after a read is issued).
module dmem_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_start,
  input  logic              dbg_abort,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [ADDR_W:0]   dbg_count,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic              dbg_busy,
  output logic              dbg_done,
  output logic [1:0]        mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, PRESENT, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nxt;
  logic [ADDR_W:0]     remaining, remaining_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [DATA_W-1:0]   dbg_data_nxt;
  logic                dbg_valid_nxt;
  logic                cpu_req;
  logic                grant_dbg;

  // 2'b11 from the MEM stage is treated as no request.
  assign cpu_req   = (cpu_rw == 2'b01) || (cpu_rw == 2'b10);
  // Debug takes the port when the CPU is idle, or forcibly once it has been denied MAX_WAIT times.
  assign grant_dbg = (state == ISSUE) && (!cpu_req || (wait_cnt == WAIT_W'(MAX_WAIT)));
  assign cpu_stall = grant_dbg && cpu_req;
  assign cpu_rdata = mem_rdata;
  assign dbg_busy  = (state != IDLE);
  assign dbg_done  = (state == DONE);

  always_comb begin
    mem_rw    = 2'b00;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant_dbg) begin
      mem_rw   = 2'b10;
      mem_addr = cur_addr;
    end else if (cpu_req) begin
      mem_rw   = cpu_rw;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    wait_cnt_nxt  = wait_cnt;
    dbg_data_nxt  = dbg_data;
    dbg_valid_nxt = dbg_valid;
    case (state)
      IDLE: begin
        if (dbg_start) begin
          if (dbg_count != '0) begin
            cur_addr_nxt  = dbg_base;
            remaining_nxt = dbg_count;
            wait_cnt_nxt  = '0;
            state_nxt     = ISSUE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        // A read granted in the same cycle as an abort still reaches memory; its data is never captured.
        if (dbg_abort) begin
          state_nxt = IDLE;
        end else if (grant_dbg) begin
          wait_cnt_nxt = '0;
          state_nxt    = WAIT_DATA;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      WAIT_DATA: begin
        if (dbg_abort) begin
          state_nxt = IDLE;
        end else begin
          dbg_data_nxt  = mem_rdata;
          dbg_valid_nxt = 1'b1;
          state_nxt     = PRESENT;
        end
      end
      PRESENT: begin
        // Abort wins over a simultaneous handshake: the word is dropped and no done pulse follows.
        if (dbg_abort) begin
          dbg_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (dbg_ready) begin
          dbg_valid_nxt = 1'b0;
          remaining_nxt = remaining - (ADDR_W+1)'(1);
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          state_nxt     = (remaining == (ADDR_W+1)'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      wait_cnt  <= wait_cnt_nxt;
      dbg_data  <= dbg_data_nxt;
      dbg_valid <= dbg_valid_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed dump scenarios against a queue-based reference model.
// Bench-side memory returns read data one cycle after a read, preloaded with 0xD000_0000 | addr.
// Model and per-cycle comparison run on the falling edge; stimulus changes 1 time unit after the rising edge.
module tb_dmem_access_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_start;
  logic          dbg_abort;
  logic [AW-1:0] dbg_base;
  logic [AW:0]   dbg_count;
  logic [DW-1:0] dbg_data;
  logic          dbg_valid;
  logic          dbg_ready;
  logic          dbg_busy;
  logic          dbg_done;
  logic [1:0]    mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_start(dbg_start), .dbg_abort(dbg_abort), .dbg_base(dbg_base), .dbg_count(dbg_count),
    .dbg_data(dbg_data), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_busy(dbg_busy), .dbg_done(dbg_done),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory
  logic [DW-1:0] mem_arr [0:31];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 32'hD000_0000 | 32'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_rw == 2'b01) mem_arr[mem_addr] <= mem_wdata;
      else if (mem_rw == 2'b10) mem_rdata <= mem_arr[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stage 0 idle, 1 waiting for a slot, 2 read in flight, 3 word offered, 4 done pulse.
  int            m_stage = 0;
  int            m_denied = 0;
  int            q[$];
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] m_data = '0;

  int            rd_log[$];
  logic [DW-1:0] beat_log[$];
  int            stall_cnt = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    bit req;
    bit g;
    int e_rw;
    if (rst) begin
      m_stage = 0; m_denied = 0; q.delete(); m_data = '0;
    end
    req  = (cpu_rw == 2'b01) || (cpu_rw == 2'b10);
    g    = (m_stage == 1) && (!req || m_denied == MW);
    e_rw = g ? 2 : (req ? int'(cpu_rw) : 0);
    chk("mem_rw", 64'(mem_rw), 64'(e_rw));
    if (g) chk("mem_addr_dbg", 64'(mem_addr), 64'(q[0]));
    else if (req) begin
      chk("mem_addr_cpu", 64'(mem_addr), 64'(cpu_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(cpu_wdata));
    end
    chk("cpu_stall", 64'(cpu_stall), 64'(g && req));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(mem_rdata));
    chk("dbg_valid", 64'(dbg_valid), 64'(m_stage == 3));
    chk("dbg_data", 64'(dbg_data), 64'(m_data));
    chk("dbg_busy", 64'(dbg_busy), 64'(m_stage != 0));
    chk("dbg_done", 64'(dbg_done), 64'(m_stage == 4));

    if (mem_rw == 2'b10) rd_log.push_back(int'(mem_addr));
    if (cpu_stall) stall_cnt++;
    if (dbg_done) done_cnt++;
    if (dbg_valid && dbg_ready && !dbg_abort) beat_log.push_back(dbg_data);

    if (!rst) begin
      case (m_stage)
        0: if (dbg_start) begin
             if (dbg_count != 0) begin
               q.delete();
               for (int i = 0; i < int'(dbg_count); i++) q.push_back((int'(dbg_base) + i) % 32);
               m_denied = 0;
               m_stage = 1;
             end else m_stage = 4;
           end
        1: if (dbg_abort) m_stage = 0;
           else if (g) begin m_word = mem_arr[q[0]]; m_denied = 0; m_stage = 2; end
           else m_denied++;
        2: if (dbg_abort) m_stage = 0;
           else begin m_data = m_word; m_stage = 3; end
        3: if (dbg_abort) m_stage = 0;
           else if (dbg_ready) begin
             void'(q.pop_front());
             m_stage = (q.size() == 0) ? 4 : 1;
           end
        default: m_stage = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); beat_log.delete(); stall_cnt = 0; done_cnt = 0;
  endtask

  task automatic start_dump(input int base, input int cnt);
    dbg_base  = AW'(base);
    dbg_count = (AW+1)'(cnt);
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (dbg_busy && n < budget) begin tick(); n++; end
    chk("wait_idle_timeout", 64'(dbg_busy), 64'(0));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!dbg_valid && n < budget) begin tick(); n++; end
    chk("wait_valid_timeout", 64'(dbg_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pos;
    int n5;
    rst = 1'b1;
    cpu_rw = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dbg_start = 1'b0; dbg_abort = 1'b0; dbg_base = '0; dbg_count = '0; dbg_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(dbg_busy), 64'(0));
    chk("rst_valid", 64'(dbg_valid), 64'(0));
    chk("rst_data", 64'(dbg_data), 64'(0));
    chk("rst_mem_rw", 64'(mem_rw), 64'(0));
    rst = 1'b0;
    tick();

    // CPU idle, three-word dump from address 2
    clear_logs();
    dbg_ready = 1'b1;
    start_dump(2, 3);
    wait_idle(50);
    chk("t1_nreads", 64'(rd_log.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", 64'(rd_log[i]), 64'(2 + i));
      chk("t1_beat", 64'(beat_log[i]), 64'(32'hD000_0002 + 32'(i)));
    end
    chk("t1_stalls", 64'(stall_cnt), 64'(0));
    chk("t1_done", 64'(done_cnt), 64'(1));

    // CPU reads every cycle: debug denied MAX_WAIT times then forced for one cycle
    cpu_rw = 2'b10; cpu_addr = 5'd7;
    tick();
    clear_logs();
    start_dump(5, 1);
    wait_idle(50);
    cpu_rw = 2'b00;
    pos = -1; n5 = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] == 5) begin n5++; if (pos < 0) pos = i; end
    chk("t2_stalls", 64'(stall_cnt), 64'(1));
    chk("t2_dbg_reads", 64'(n5), 64'(1));
    chk("t2_forced_pos", 64'(pos), 64'(5));
    chk("t2_beat", 64'(beat_log[0]), 64'(32'hD000_0005));
    chk("t2_done", 64'(done_cnt), 64'(1));

    // Address wrap
    clear_logs();
    start_dump(30, 4);
    wait_idle(60);
    chk("t3_nreads", 64'(rd_log.size()), 64'(4));
    chk("t3_a0", 64'(rd_log[0]), 64'(30));
    chk("t3_a1", 64'(rd_log[1]), 64'(31));
    chk("t3_a2", 64'(rd_log[2]), 64'(0));
    chk("t3_a3", 64'(rd_log[3]), 64'(1));
    chk("t3_beat2", 64'(beat_log[2]), 64'(32'hD000_0000));

    // Full-depth dump
    clear_logs();
    start_dump(0, 32);
    wait_idle(400);
    chk("t3b_nreads", 64'(rd_log.size()), 64'(32));
    chk("t3b_nbeats", 64'(beat_log.size()), 64'(32));
    chk("t3b_last", 64'(beat_log[31]), 64'(32'hD000_001F));
    chk("t3b_done", 64'(done_cnt), 64'(1));

    // Debug stalls on dbg_ready while CPU writes pass through
    clear_logs();
    dbg_ready = 1'b0;
    start_dump(10, 2);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      cpu_rw = 2'b01; cpu_addr = AW'(20 + i); cpu_wdata = 32'hCAFE_0000 + 32'(i);
      tick();
    end
    cpu_rw = 2'b00;
    dbg_ready = 1'b1;
    wait_idle(50);
    chk("t4_stalls", 64'(stall_cnt), 64'(0));
    chk("t4_nreads", 64'(rd_log.size()), 64'(2));
    chk("t4_wr20", 64'(mem_arr[20]), 64'(32'hCAFE_0000));
    chk("t4_wr24", 64'(mem_arr[24]), 64'(32'hCAFE_0004));
    chk("t4_beat0", 64'(beat_log[0]), 64'(32'hD000_000A));
    chk("t4_beat1", 64'(beat_log[1]), 64'(32'hD000_000B));

    // Zero-length dump
    clear_logs();
    start_dump(7, 0);
    chk("t5_done_now", 64'(dbg_done), 64'(1));
    wait_idle(10);
    chk("t5_done", 64'(done_cnt), 64'(1));
    chk("t5_nreads", 64'(rd_log.size()), 64'(0));

    // Abort while presenting, overriding a same-cycle handshake
    clear_logs();
    dbg_ready = 1'b0;
    start_dump(3, 3);
    wait_valid(20);
    dbg_abort = 1'b1; dbg_ready = 1'b1;
    tick();
    dbg_abort = 1'b0; dbg_ready = 1'b0;
    chk("t6_abort_busy", 64'(dbg_busy), 64'(0));
    chk("t6_abort_valid", 64'(dbg_valid), 64'(0));
    tick();
    chk("t6_abort_done", 64'(done_cnt), 64'(0));
    chk("t6_abort_beats", 64'(beat_log.size()), 64'(0));

    // Start while busy is ignored
    clear_logs();
    dbg_ready = 1'b1;
    start_dump(8, 2);
    tick();
    start_dump(0, 5);
    wait_idle(50);
    chk("t6_busy_nreads", 64'(rd_log.size()), 64'(2));
    chk("t6_busy_a0", 64'(rd_log[0]), 64'(8));
    chk("t6_busy_a1", 64'(rd_log[1]), 64'(9));
    chk("t6_busy_done", 64'(done_cnt), 64'(1));

    // Asynchronous reset while a read is in flight
    clear_logs();
    start_dump(12, 2);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(dbg_busy), 64'(0));
    chk("t6_rst_valid", 64'(dbg_valid), 64'(0));
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_rst_done", 64'(done_cnt), 64'(0));
    chk("t6_rst_data", 64'(dbg_data), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
